multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM that sequences the fetch/decode/execute datapath: fetches into an
//  instruction register, classifies the opcode, and issues one-hot-in-time enables for the
//  register file, memory, PC and write-back muxes.
//  Sits between instruction/data memory handshakes and the immediate/decode datapath. Traps on
//  illegal opcodes and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  16            max wait cycles on any memory handshake before TRAP (>=1)
//  NOP_INSTR    32'h00000013  value loaded into ir on reset (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous active-high reset
//  imem_req     out  1   instruction fetch request
//  imem_ready   in   1   fetch data valid; transfer when imem_req & imem_ready
//  imem_rdata   in   32  fetched instruction
//  ir           out  32  instruction register, drives decode/immediate logic
//  br_taken     in   1   branch compare result from ALU, valid in EXEC
//  dmem_req     out  1   data memory request
//  dmem_we      out  1   1 = store, 0 = load; valid while dmem_req
//  dmem_ready   in   1   data transfer complete when dmem_req & dmem_ready
//  alu_src_imm  out  1   ALU operand B = imm (1) or rs2 (0)
//  reg_we       out  1   register file write strobe
//  wb_sel       out  2   0 ALU result, 1 load data, 2 pc+4
//  pc_we        out  1   PC write strobe
//  pc_sel       out  2   0 pc+4, 1 pc+imm, 2 (rs1+imm)&~1
//  retire       out  1   one-cycle pulse per completed instruction
//  trap         out  1   sticky; set on TRAP entry
//  trap_cause   out  2   0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
// BEHAVIOUR
//  - Reset (async): state=FETCH, ir=NOP_INSTR, trap=0, trap_cause=0, timeout counter=0; all
//    strobes and requests 0 during reset. First imem_req asserts on the first clock after release.
//  - States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore (decoded from state + ir[6:0]).
//  - FETCH: imem_req=1 held until imem_ready; on transfer ir<=imem_rdata, -> DECODE.
//  - DECODE: classify ir[6:0]: R 0110011, I 0010011, LOAD 0000011, STORE 0100011,
//    BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; else -> TRAP cause 1.
//  - EXEC: alu_src_imm=1 for all except R/BRANCH. BRANCH: pc_we=1, pc_sel=br_taken?1:0, retire=1,
//    -> FETCH. LOAD/STORE -> MEM; all others -> WB.
//  - MEM: dmem_req=1, dmem_we=(STORE), held until dmem_ready. STORE on transfer: pc_we=1, pc_sel=0,
//    retire=1, -> FETCH. LOAD on transfer -> WB.
//  - WB: reg_we=1, pc_we=1, retire=1 in the same cycle; wb_sel=1 LOAD, 2 JAL/JALR, else 0;
//    pc_sel=1 JAL, 2 JALR, else 0. -> FETCH. reg_we asserted even for rd=x0 (regfile ignores).
//  - Latency with zero-wait memory: BRANCH 3, STORE 4, ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5 cycles.
//  - Timeout: counter cleared on entry to FETCH/MEM, increments each cycle with req & !ready;
//    when it reaches MEM_TIMEOUT without transfer -> TRAP (cause 2 or 3). Ready on the same cycle
//    the count reaches MEM_TIMEOUT counts as success. Counter saturates; width $clog2(MEM_TIMEOUT+1).
//  - TRAP: all strobes/requests 0, trap=1, trap_cause held; exits only via rst.
//  - Reset mid-handshake drops req immediately; no pending transfer survives reset.
//  - At most one of reg_we/pc_we-pairs per instruction; retire exactly once per instruction.
// STRUCTURE
//  - Shared package riscv_pkg: opcode localparams, state enum, wb_sel/pc_sel/trap_cause codes.
//  - Sub-module ctrl_opclass: combinational ir[6:0] -> instruction class + legal flag.
//  - Top holds state register, ir, timeout counter, trap flags, output decode.
// TESTING
//  1. Reset then imem_ready=1 always, rdata=add(0x002081B3): FETCH..WB in 4 cycles, reg_we=1,
//     wb_sel=0, pc_sel=0, single retire pulse in WB.
//  2. lw (0x0000A103) with dmem_ready delayed 3 cycles: dmem_req held 4 cycles, dmem_we=0,
//     WB wb_sel=1, total 8 cycles.
//  3. beq (0x00208463) with br_taken=1 then =0: pc_we in EXEC with pc_sel=1 then 0, no reg_we.
//  4. jalr (0x000080E7): WB reg_we=1, wb_sel=2, pc_sel=2; jal (0x008000EF): pc_sel=1.
//  5. Illegal opcode 0xFFFFFFFF: TRAP after DECODE, trap=1, cause=1, no strobes afterwards.
//  6. imem_ready held 0 for MEM_TIMEOUT cycles -> TRAP cause 2; assert rst mid-MEM on sw: outputs 0
//     asynchronously, ir=NOP_INSTR, fetch restarts cleanly.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, state and class enums,
// mux select / trap cause codes and small decode helpers.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_R       = 4'd0,
        CL_I       = 4'd1,
        CL_LOAD    = 4'd2,
        CL_STORE   = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_JAL     = 4'd5,
        CL_JALR    = 4'd6,
        CL_LUI     = 4'd7,
        CL_AUIPC   = 4'd8,
        CL_ILLEGAL = 4'd9
    } opclass_e;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_LOAD  = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    function automatic logic uses_imm(input opclass_e cls);
        return !((cls == CL_R) || (cls == CL_BRANCH));
    endfunction

    function automatic logic [1:0] wb_sel_of(input opclass_e cls);
        logic [1:0] sel;
        case (cls)
            CL_LOAD: sel = WB_LOAD;
            CL_JAL:  sel = WB_PC4;
            CL_JALR: sel = WB_PC4;
            default: sel = WB_ALU;
        endcase
        return sel;
    endfunction

    function automatic logic [1:0] pc_sel_of(input opclass_e cls);
        logic [1:0] sel;
        case (cls)
            CL_JAL:  sel = PC_IMM;
            CL_JALR: sel = PC_JALR;
            default: sel = PC_PLUS4;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// Combinational opcode classifier: ir[6:0] -> instruction class plus legal flag.
module multicycle_ctrl_opclass
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_e   op_class,
    output logic       legal
);

    // Map each recognised major opcode to its class; anything else is illegal.
    always_comb begin
        op_class = CL_ILLEGAL;
        legal    = 1'b1;
        case (opcode)
            OP_R:      op_class = CL_R;
            OP_I:      op_class = CL_I;
            OP_LOAD:   op_class = CL_LOAD;
            OP_STORE:  op_class = CL_STORE;
            OP_BRANCH: op_class = CL_BRANCH;
            OP_JAL:    op_class = CL_JAL;
            OP_JALR:   op_class = CL_JALR;
            OP_LUI:    op_class = CL_LUI;
            OP_AUIPC:  op_class = CL_AUIPC;
            default: begin
                op_class = CL_ILLEGAL;
                legal    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute control FSM with memory handshake timeouts and a sticky trap.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic        br_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam int            CW          = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    state_e        state_q, state_d;
    logic [31:0]   ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trap_q, trap_d;
    logic [1:0]    cause_q, cause_d;
    // started_q keeps imem_req low until the first clock after reset release.
    logic          started_q, started_d;

    opclass_e      op_class_s;
    logic          legal_s;

    multicycle_ctrl_opclass u_opclass (
        .opcode   (ir_q[6:0]),
        .op_class (op_class_s),
        .legal    (legal_s)
    );

    // State, instruction register, timeout counter and trap flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= NOP_INSTR;
            cnt_q     <= CNT_ZERO;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            started_q <= started_d;
        end
    end

    // Next-state logic, including handshake timeouts and trap entry.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        started_d = 1'b1;
        case (state_q)
            ST_FETCH: begin
                if (!started_q) begin
                    cnt_d = CNT_ZERO;
                end else if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_IMEM_TO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DECODE: begin
                if (legal_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (op_class_s == CL_BRANCH) begin
                    state_d = ST_FETCH;
                    cnt_d   = CNT_ZERO;
                end else if ((op_class_s == CL_LOAD) || (op_class_s == CL_STORE)) begin
                    state_d = ST_MEM;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (op_class_s == CL_STORE) begin
                        state_d = ST_FETCH;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_DMEM_TO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                cnt_d   = CNT_ZERO;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
                trap_d  = 1'b1;
            end
        endcase
    end

    // Output decode from state and instruction class; branch and store completion see their inputs.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        retire      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = started_q;
            end
            ST_EXEC: begin
                alu_src_imm = uses_imm(op_class_s);
                if (op_class_s == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                    retire = 1'b1;
                end else begin
                    pc_we  = 1'b0;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_class_s == CL_STORE);
                if ((op_class_s == CL_STORE) && dmem_ready) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end else begin
                    retire = 1'b0;
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                wb_sel = wb_sel_of(op_class_s);
                pc_sel = pc_sel_of(op_class_s);
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign ir         = ir_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule
